seq_input_conditioner: RTL

Input-conditioning stage in front of the sequence-detector FSM. Synchronizes the raw push-button and data switch into the system clock domain and debounces the button. Emits exactly one single-cycle `step` pulse per physical press, together with a `w_out` value captured on that pulse. The detector runs on `clk` and advances only when `step` is high, instead of using the bouncy button as its clock.

---
 rtl/seq_pkg.sv | 17 +
 rtl/bit_sync.sv | 27 ++
 rtl/seq_input_conditioner.sv | 124 ++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and default constants for the sequence-detector input stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seq_pkg;

  // Debounce FSM states, 2-bit binary encoding
  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } dbnc_state_t;

  localparam int SEQ_SYNC_STAGES     = 2;
  localparam int SEQ_DEBOUNCE_CYCLES = 500000;  // 10 ms at 50 MHz

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer bringing one asynchronous bit into the clk domain.
// Latency: STAGES cycles from input sample to output.
// Backpressure: none; free-running shift chain.
module bit_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw bit through the chain; reset loads the idle value everywhere
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/seq_input_conditioner.sv
// Synchronizes and debounces the push-button, emits one step pulse per press with captured w.
// Latency: step observed SYNC_STAGES+DEBOUNCE_CYCLES edges after key_n is first sampled low.
// Backpressure: none; step is a fire-and-forget single-cycle strobe.
module seq_input_conditioner
  import seq_pkg::*;
#(
  parameter int SYNC_STAGES     = SEQ_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = SEQ_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  input  logic sw_w,
  output logic step,
  output logic w_out,
  output logic pressed
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  // The sample that would bring the count to DEBOUNCE_CYCLES triggers the exit,
  // so the stored count never has to hold more than DEBOUNCE_CYCLES-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          key_s;
  logic          sw_s;
  dbnc_state_t   state_q;
  dbnc_state_t   state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          step_d;

  // Button idles released (high); switch idles low
  bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_key_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_n),
    .q   (key_s)
  );

  bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sw_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw_w),
    .q   (sw_s)
  );

  // State and stability counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: count consecutive samples at the new level, fall back on any glitch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RELEASED: begin
        if (!key_s) begin
          state_d = PRESS_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_CHK: begin
        if (key_s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_d = RELEASE_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_CHK: begin
        if (!key_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: debounced level, and the press-confirmed event that arms step
  always_comb begin
    pressed = state_q inside {PRESSED, RELEASE_CHK};
    step_d  = (state_q == PRESS_CHK) && (state_d == PRESSED);
  end

  // Registered step strobe with the switch value captured on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      step  <= 1'b0;
      w_out <= 1'b0;
    end else begin
      step <= step_d;
      if (step_d) begin
        w_out <= sw_s;
      end
    end
  end

endmodule
